fusion_mac_pipe: RTL and testbench
==================================

Name: fusion_mac_pipe

Overview:
- Parametrised, pipelined successor to the bit-level fusion multiplier.
- Four fused lanes; each lane multiplies a BW-bit activation brick by a BW-bit weight brick.
- Lane products are shifted per precision mode, summed, and accumulated across a burst of beats.
- Sits in a PE column: the tile controller streams operand beats in; the column adder collects one accumulated result per burst.

Parameters:
- BW, 2, brick width in bits per lane. Operand ports are 4*BW bits wide.
- ACC_WIDTH, 32, accumulator and output width. Must be at least 4*BW+2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  beat valid; no backpressure
- in_first  in  1  first beat of burst; qualified by in_valid
- in_last  in  1  last beat of burst; qualified by in_valid
- sign_mode  in  2  [1]=1: activation unsigned; [0]=1: weight unsigned
- mode  in  2  [1]=1: activation split into BW-bit values; [0]=1: weight split into BW-bit values
- a  in  4*BW  activation bricks; lane i = a[i*BW +: BW]
- b  in  4*BW  weight bricks; lane i = b[i*BW +: BW]
- out_valid  out  1  one-cycle pulse: burst result on out
- out  out  ACC_WIDTH  signed accumulated burst result

Behaviour:
- Reset (reset==0 at a clk edge) clears all pipeline valid bits, the accumulator, out and out_valid to 0. A burst in flight is discarded; no out_valid is produced for it.
- Control bits (mode, sign_mode, in_first, in_last) are captured with the data each beat, so mode may change beat to beat.
- Derived flags, evaluated per beat:
  - a_sign = ~sign_mode[1] & ~mode[1]
  - b_sign = ~sign_mode[0] & ~mode[0]
  - s_a = mode[1] ? 0 : BW
  - s_b = mode[0] ? 0 : BW
- Lane products (exact, signed arithmetic):
  - Lane 0: both bricks unsigned; shift 0.
  - Lane 1: a brick signed iff a_sign, b brick unsigned; shift s_a.
  - Lane 2: a brick unsigned, b brick signed iff b_sign; shift s_b.
  - Lane 3: a brick signed iff a_sign, b brick signed iff b_sign; shift s_a+s_b.
  - sum = sum of the four shifted products, computed exactly in 4*BW+2 bits signed, then sign-extended to ACC_WIDTH.
- Full-width operand packing (caller's responsibility):
  - a = {a_hi, a_lo, a_hi, a_lo}
  - b = {b_hi, b_hi, b_lo, b_lo}
- Pipeline, three register stages, fully pipelined, throughput 1 beat/cycle:
  - S1 (edge k): register operands, controls and valid.
  - S2 (edge k+1): register the lane products and their summed result.
  - S3 (edge k+2): accumulator update.
- Accumulator update at S3, only when the S3 beat is valid:
  - first=1: acc = sum
  - first=0: acc = acc + sum, wrapping modulo 2^ACC_WIDTH
- Output:
  - If the S3 beat has last=1: out <= the new acc value and out_valid=1 for exactly the cycle after edge k+2.
  - Otherwise out_valid=0.
  - out holds its value until the next out_valid.
- Boundary cases:
  - first and last on the same beat: out = that beat's sum.
  - Bubbles (in_valid=0) leave acc untouched; a burst may contain arbitrary gaps.
  - A first beat with no preceding last silently restarts accumulation.
  - A beat with first=0 following reset accumulates onto acc=0.
  - Back-to-back bursts (last at beat k, first at beat k+1): the results do not interfere.

Optional Feature:
- Macro: FUSION_MAC_SATURATE_EN.
- Defined:
  - Accumulate adds clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Add output port sat (1 bit): pulses with out_valid when any add in that burst clamped. The sticky flag clears on first.
- Undefined:
  - Accumulation wraps.
  - Port sat does not exist.

Test Plan:
- BW=2, mode=3, sign_mode=3, a=0xFF, b=0xFF, first=last=1 -> 3 cycles later out_valid=1, out=36.
- Unsigned full-width 13*10: mode=0, sign_mode=3, a=0xDD, b=0xAA, first=last=1 -> out=130.
- Signed full-width -3*5: mode=0, sign_mode=0, a=0xDD, b=0x55 -> out=-15 (0xFFFFFFF1).
- Burst of three mode-3 beats (36, 36, then a=0x55,b=0x55 giving 4) with a 2-cycle bubble before the last beat -> single out_valid pulse, out=76. No pulse earlier.
- Assert reset (reset=0) one cycle after a last beat is sampled -> no out_valid, out=0, acc=0. The next single-beat burst gives the correct standalone value.
- With FUSION_MAC_SATURATE_EN and ACC_WIDTH=10: five mode-0 unsigned beats of 0xFF*0xFF=225 -> out=511, sat=1. Without the macro: out=1125 mod 1024 = 101.

Source files
------------

// File: rtl/fusion_mac_pipe_if.sv
// rtl/fusion_mac_pipe_if.sv - operand beat and burst result bundle for fusion_mac_pipe (FUSION_MAC_SATURATE_EN adds sat)
interface fusion_mac_pipe_if #(
    parameter int BW        = 2,
    parameter int ACC_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_first;
    logic                 in_last;
    logic [1:0]           sign_mode;
    logic [1:0]           mode;
    logic [4*BW-1:0]      a;
    logic [4*BW-1:0]      b;
    logic                 out_valid;
    logic [ACC_WIDTH-1:0] out;
`ifdef FUSION_MAC_SATURATE_EN
    logic                 sat;

    modport master (
        output in_valid, in_first, in_last, sign_mode, mode, a, b,
        input  out_valid, out, sat
    );

    modport slave (
        input  in_valid, in_first, in_last, sign_mode, mode, a, b,
        output out_valid, out, sat
    );
`else
    modport master (
        output in_valid, in_first, in_last, sign_mode, mode, a, b,
        input  out_valid, out
    );

    modport slave (
        input  in_valid, in_first, in_last, sign_mode, mode, a, b,
        output out_valid, out
    );
`endif
endinterface

// File: rtl/fusion_mac_pipe.sv
// rtl/fusion_mac_pipe.sv - 3-stage four-lane fused brick MAC with burst accumulation (FUSION_MAC_SATURATE_EN: clamping adds + sat)
module fusion_mac_pipe #(
    parameter int BW        = 2,
    parameter int ACC_WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    fusion_mac_pipe_if.slave bus
);
    localparam int SW = 4*BW + 2;
    localparam int PW = 2*BW + 2;

    logic                 s1_valid;
    logic                 s1_first;
    logic                 s1_last;
    logic [1:0]           s1_sign_mode;
    logic [1:0]           s1_mode;
    logic [4*BW-1:0]      s1_a;
    logic [4*BW-1:0]      s1_b;

    logic                 s2_valid;
    logic                 s2_first;
    logic                 s2_last;
    logic signed [SW-1:0] s2_sum;

    logic signed [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0]        result;
    logic                        result_valid;

    logic                 a_sign;
    logic                 b_sign;
    int unsigned          s_a;
    int unsigned          s_b;
    logic signed [SW-1:0] term [4];
    logic signed [SW-1:0] sum_c;

    // One lane: each brick widened by one bit so signed and unsigned share one multiplier.
    function automatic logic signed [SW-1:0] lane_term(
        input logic [BW-1:0] x, input logic xs,
        input logic [BW-1:0] y, input logic ys,
        input int unsigned sh
    );
        logic signed [BW:0]    xe;
        logic signed [BW:0]    ye;
        logic signed [PW-1:0]  p;
        logic signed [SW-1:0]  pe;
        xe = {xs & x[BW-1], x};
        ye = {ys & y[BW-1], y};
        p  = PW'(xe) * PW'(ye);
        pe = SW'(p);
        return pe <<< sh;
    endfunction

    always_comb begin
        a_sign  = ~s1_sign_mode[1] & ~s1_mode[1];
        b_sign  = ~s1_sign_mode[0] & ~s1_mode[0];
        s_a     = s1_mode[1] ? 0 : BW;
        s_b     = s1_mode[0] ? 0 : BW;
        term[0] = lane_term(s1_a[0*BW +: BW], 1'b0,   s1_b[0*BW +: BW], 1'b0,   0);
        term[1] = lane_term(s1_a[1*BW +: BW], a_sign, s1_b[1*BW +: BW], 1'b0,   s_a);
        term[2] = lane_term(s1_a[2*BW +: BW], 1'b0,   s1_b[2*BW +: BW], b_sign, s_b);
        term[3] = lane_term(s1_a[3*BW +: BW], a_sign, s1_b[3*BW +: BW], b_sign, s_a + s_b);
        sum_c   = term[0] + term[1] + term[2] + term[3];
    end

    logic signed [ACC_WIDTH-1:0] sum_ext;
    logic signed [ACC_WIDTH:0]   acc_wide;
    logic signed [ACC_WIDTH-1:0] acc_next;

    assign sum_ext  = ACC_WIDTH'(s2_sum);
    assign acc_wide = {acc[ACC_WIDTH-1], acc} + {sum_ext[ACC_WIDTH-1], sum_ext};

`ifdef FUSION_MAC_SATURATE_EN
    logic clamp_hit;
    logic sat_sticky;
    logic sat_flag;
    logic overflow;

    // Two's-complement overflow shows as disagreement between the guard bit and the MSB.
    assign overflow  = acc_wide[ACC_WIDTH] ^ acc_wide[ACC_WIDTH-1];
    assign clamp_hit = ~s2_first & overflow;

    always_comb begin
        acc_next = acc_wide[ACC_WIDTH-1:0];
        if (s2_first)
            acc_next = sum_ext;
        else if (overflow)
            acc_next = acc_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sat_sticky <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            sat_flag <= 1'b0;
            if (s2_valid) begin
                sat_sticky <= s2_first ? 1'b0 : (sat_sticky | clamp_hit);
                if (s2_last)
                    sat_flag <= s2_first ? 1'b0 : (sat_sticky | clamp_hit);
            end
        end
    end

    assign bus.sat = sat_flag;
`else
    assign acc_next = s2_first ? sum_ext : acc_wide[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid     <= 1'b0;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
            s1_sign_mode <= '0;
            s1_mode      <= '0;
            s1_a         <= '0;
            s1_b         <= '0;
            s2_valid     <= 1'b0;
            s2_first     <= 1'b0;
            s2_last      <= 1'b0;
            s2_sum       <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            s1_valid     <= bus.in_valid;
            s1_first     <= bus.in_first;
            s1_last      <= bus.in_last;
            s1_sign_mode <= bus.sign_mode;
            s1_mode      <= bus.mode;
            s1_a         <= bus.a;
            s1_b         <= bus.b;

            s2_valid     <= s1_valid;
            s2_first     <= s1_first;
            s2_last      <= s1_last;
            s2_sum       <= sum_c;

            result_valid <= s2_valid & s2_last;
            if (s2_valid) begin
                acc <= acc_next;
                if (s2_last)
                    result <= acc_next;
            end
        end
    end

    assign bus.out_valid = result_valid;
    assign bus.out       = result;
endmodule

// File: tb/tb_fusion_mac_pipe.sv
// tb/tb_fusion_mac_pipe.sv - scoreboard bench for fusion_mac_pipe (honours FUSION_MAC_SATURATE_EN)
module tb_fusion_mac_pipe;
    localparam int BW  = 2;
    localparam int AW  = 32;
    localparam int SAW = 10;
    localparam int NW  = 4*BW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fusion_mac_pipe_if #(.BW(BW), .ACC_WIDTH(AW))  m ();
    fusion_mac_pipe_if #(.BW(BW), .ACC_WIDTH(SAW)) s ();

    fusion_mac_pipe #(.BW(BW), .ACC_WIDTH(AW))  dut   (.clk(clk), .reset(reset), .bus(m.slave));
    fusion_mac_pipe #(.BW(BW), .ACC_WIDTH(SAW)) dut_s (.clk(clk), .reset(reset), .bus(s.slave));

    int total = 0;
    int bad   = 0;
    logic [AW-1:0] exp_q [$];
    longint        acc_model;
    logic [AW-1:0] exp_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic longint brick(input logic [BW-1:0] v, input bit sgn);
        longint r;
        r = longint'(v);
        if (sgn && v[BW-1]) r = r - (longint'(1) << BW);
        return r;
    endfunction

    // Reference: four brick products weighted by powers of two, straight from the lane table.
    function automatic longint model_sum(input logic [1:0] md, input logic [1:0] sm,
                                         input logic [NW-1:0] av, input logic [NW-1:0] bv);
        bit     as_;
        bit     bs_;
        int     sa;
        int     sb;
        longint r;
        as_ = !sm[1] && !md[1];
        bs_ = !sm[0] && !md[0];
        sa  = md[1] ? 0 : BW;
        sb  = md[0] ? 0 : BW;
        r   = brick(av[0 +: BW], 0) * brick(bv[0 +: BW], 0);
        r  += brick(av[BW +: BW], as_) * brick(bv[BW +: BW], 0) * (longint'(1) << sa);
        r  += brick(av[2*BW +: BW], 0) * brick(bv[2*BW +: BW], bs_) * (longint'(1) << sb);
        r  += brick(av[3*BW +: BW], as_) * brick(bv[3*BW +: BW], bs_) * (longint'(1) << (sa + sb));
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset && m.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("burst_out", 64'(m.out), 64'(exp_e));
`ifdef FUSION_MAC_SATURATE_EN
                check("main_sat", 64'(m.sat), 64'd0);
`endif
            end
        end
    end

    task automatic beat(input bit first, input bit last, input logic [1:0] md, input logic [1:0] sm,
                        input logic [NW-1:0] av, input logic [NW-1:0] bv,
                        input bit use_exp, input logic [AW-1:0] exp_v);
        longint t;
        @(negedge clk);
        m.in_valid  = 1'b1;
        m.in_first  = first;
        m.in_last   = last;
        m.mode      = md;
        m.sign_mode = sm;
        m.a         = av;
        m.b         = bv;
        if (first) acc_model = model_sum(md, sm, av, bv);
        else       acc_model = acc_model + model_sum(md, sm, av, bv);
        t = acc_model;
        if (last) exp_q.push_back(use_exp ? exp_v : t[AW-1:0]);
        @(posedge clk);
        #1 m.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bit            got;
        logic [SAW-1:0] s_out;
        logic           s_sat;
        int             nb;
        reset = 1'b0;
        acc_model = 0;
        m.in_valid = 0; m.in_first = 0; m.in_last = 0; m.mode = 0; m.sign_mode = 0; m.a = 0; m.b = 0;
        s.in_valid = 0; s.in_first = 0; s.in_last = 0; s.mode = 0; s.sign_mode = 0; s.a = 0; s.b = 0;
        s_sat = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(m.out_valid), 64'd0);
        check("reset_out", 64'(m.out), 64'd0);
        check("reset_small_out", 64'(s.out), 64'd0);
        reset = 1'b1;
        idle(2);

        beat(1, 1, 2'd3, 2'd3, 8'hFF, 8'hFF, 1, 32'd36);
        beat(1, 1, 2'd0, 2'd3, 8'hDD, 8'hAA, 1, 32'd130);
        beat(1, 1, 2'd0, 2'd0, 8'hDD, 8'h55, 1, 32'hFFFF_FFF1);
        drain();

        beat(1, 0, 2'd3, 2'd3, 8'hFF, 8'hFF, 0, '0);
        beat(0, 0, 2'd3, 2'd3, 8'hFF, 8'hFF, 0, '0);
        idle(2);
        beat(0, 1, 2'd3, 2'd3, 8'h55, 8'h55, 1, 32'd76);
        drain();

        // Last beat sampled, reset lands on the following edge: that result must vanish.
        beat(1, 1, 2'd3, 2'd3, 8'hFF, 8'hFF, 1, 32'd36);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        acc_model = 0;
        @(negedge clk);
        check("midreset_out_valid", 64'(m.out_valid), 64'd0);
        check("midreset_out", 64'(m.out), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(5);
        check("postreset_out", 64'(m.out), 64'd0);
        beat(0, 1, 2'd3, 2'd3, 8'h55, 8'h55, 1, 32'd4);
        drain();

        beat(1, 1, 2'd3, 2'd3, 8'hFF, 8'hFF, 1, 32'd36);
        beat(1, 1, 2'd3, 2'd3, 8'h55, 8'h55, 1, 32'd4);
        drain();

        for (int k = 0; k < 40; k++) begin
            nb = $urandom_range(1, 4);
            for (int j = 0; j < nb; j++) begin
                beat(j == 0, (j == nb - 1) && ($urandom_range(0, 7) != 0),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     NW'($urandom), NW'($urandom), 0, '0);
                idle($urandom_range(0, 2));
            end
        end
        drain();

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s.in_valid = 1'b1; s.in_first = (i == 0); s.in_last = (i == 4);
            s.mode = 2'd0; s.sign_mode = 2'd3; s.a = 8'hFF; s.b = 8'hFF;
            @(posedge clk);
            #1 s.in_valid = 1'b0;
        end
        got = 1'b0;
        s_out = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (s.out_valid) begin
                got = 1'b1;
                s_out = s.out;
`ifdef FUSION_MAC_SATURATE_EN
                s_sat = s.sat;
`endif
            end
        end
        check("small_out_valid_seen", 64'(got), 64'd1);
`ifdef FUSION_MAC_SATURATE_EN
        check("small_sat_out", 64'(s_out), 64'd511);
        check("small_sat_flag", 64'(s_sat), 64'd1);
`else
        check("small_wrap_out", 64'(s_out), 64'd101);
        check("small_sat_flag", 64'(s_sat), 64'd0);
`endif

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
